// File: rtl/pre_if_stage_pkg.sv
// pre_if_stage_pkg: shared definitions for the pre-IF fetch stage.
//   pfs_state_e     - fetch FSM states (S_IDLE / S_REQ / S_HOLD)
//   PFS_RESET_PC    - first fetch address after reset
//   PFS_EXCP_ENTRY  - exception handler entry
//   SRAM_SIZE_WORD  - SRAM size code for a 32-bit access
//   pick_redirect   - redirect target priority: excp > eret > branch
package pre_if_stage_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } pfs_state_e;

    localparam logic [31:0] PFS_RESET_PC   = 32'hbfc00000;
    localparam logic [31:0] PFS_EXCP_ENTRY = 32'hbfc00380;
    localparam logic [1:0]  SRAM_SIZE_WORD = 2'b10;

    function automatic logic [31:0] pick_redirect(
        input logic        excp,
        input logic        eret,
        input logic [31:0] excp_entry,
        input logic [31:0] epc,
        input logic [31:0] br_target
    );
        if (excp)
            return excp_entry;
        else if (eret)
            return epc;
        else
            return br_target;
    endfunction

endpackage

// File: rtl/pre_if_stage_redirect_buf.sv
// pfs_redirect_buf: redirect priority mux plus the pending-target register.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   excp_flush/eret_flush - flush pulses from WB
//   br_taken/br_target    - branch redirect from ID
//   cp0_epc               - eret target
//   take_new              - the incoming redirect is loaded into pc this cycle
//   take_pend             - the stored pending target is loaded into pc this cycle
//   redirect              - a redirect is being captured this cycle
//   flush                 - the captured redirect is a flush (excp or eret)
//   redirect_target       - winning target of this cycle
//   pend_valid/pend_target- stored redirect awaiting use
module pfs_redirect_buf import pre_if_stage_pkg::*; #(
    parameter logic [31:0] EXCP_ENTRY = PFS_EXCP_ENTRY
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        excp_flush,
    input  logic        eret_flush,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic [31:0] cp0_epc,
    input  logic        take_new,
    input  logic        take_pend,
    output logic        redirect,
    output logic        flush,
    output logic [31:0] redirect_target,
    output logic        pend_valid,
    output logic [31:0] pend_target
);

    logic pend_flush;

    // A branch arriving after a flush is wrong-path and must not overwrite
    // the pending flush target.
    always_comb begin
        flush           = excp_flush | eret_flush;
        redirect        = flush | (br_taken & ~(pend_valid & pend_flush));
        redirect_target = pick_redirect(excp_flush, eret_flush, EXCP_ENTRY,
                                        cp0_epc, br_target);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_valid  <= 1'b0;
            pend_flush  <= 1'b0;
            pend_target <= '0;
        end else if (redirect && !take_new) begin
            pend_valid  <= 1'b1;
            pend_flush  <= flush;
            pend_target <= redirect_target;
        end else if (take_new || take_pend) begin
            pend_valid  <= 1'b0;
            pend_flush  <= 1'b0;
        end
    end

endmodule

// File: rtl/pre_if_stage.sv
// pre_if_stage: pre-IF stage of the 5-stage MIPS core. Owns the fetch PC,
// issues requests on the SRAM-like instruction bus and hands accepted PCs
// to if_stage.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   fs_allowin                 - IF can take a PC this cycle
//   br_stall                   - ID branch operands not ready; blocks new requests
//   br_taken, br_target        - branch redirect (delay slot already issued)
//   excp_flush, eret_flush     - flush pulses from WB
//   cp0_epc                    - eret target
//   inst_sram_req/wr/size/addr - instruction bus request (wr=0, size=word)
//   inst_sram_addr_ok          - request accepted
//   to_fs_valid, to_fs_pc      - PC handoff to IF
//   to_fs_excp                 - AdEL flag for the handed PC
//   fs_discard                 - IF drops the next data_ok beat
// Build option: PFS_ADEL_CHECK_EN enables the misaligned-PC (AdEL) check;
// without it to_fs_excp is tied 0 and every PC is requested.
module pre_if_stage import pre_if_stage_pkg::*; #(
    parameter logic [31:0] RESET_PC   = PFS_RESET_PC,
    parameter logic [31:0] EXCP_ENTRY = PFS_EXCP_ENTRY
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fs_allowin,
    input  logic        br_stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        excp_flush,
    input  logic        eret_flush,
    input  logic [31:0] cp0_epc,
    output logic        inst_sram_req,
    output logic        inst_sram_wr,
    output logic [1:0]  inst_sram_size,
    output logic [31:0] inst_sram_addr,
    input  logic        inst_sram_addr_ok,
    output logic        to_fs_valid,
    output logic [31:0] to_fs_pc,
    output logic        to_fs_excp,
    output logic        fs_discard
);

    pfs_state_e  state, state_next;
    logic [31:0] pc, pc_d, hold_pc;
    logic        pc_load, hold_load;
    logic        cancel, cancel_d;
    logic        take_new, take_pend;
    logic        misaligned;
    logic        redirect, flush;
    logic [31:0] redirect_target;
    logic        pend_valid;
    logic [31:0] pend_target;

`ifdef PFS_ADEL_CHECK_EN
    logic adel, adel_d;
    assign misaligned = (state == S_REQ) && (pc[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    pfs_redirect_buf #(
        .EXCP_ENTRY (EXCP_ENTRY)
    ) u_redirect_buf (
        .clk             (clk),
        .reset           (reset),
        .excp_flush      (excp_flush),
        .eret_flush      (eret_flush),
        .br_taken        (br_taken),
        .br_target       (br_target),
        .cp0_epc         (cp0_epc),
        .take_new        (take_new),
        .take_pend       (take_pend),
        .redirect        (redirect),
        .flush           (flush),
        .redirect_target (redirect_target),
        .pend_valid      (pend_valid),
        .pend_target     (pend_target)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    // Next-state and datapath control
    always_comb begin
        state_next = state;
        pc_load    = 1'b0;
        pc_d       = pc;
        hold_load  = 1'b0;
        cancel_d   = cancel;
        take_new   = 1'b0;
        take_pend  = 1'b0;
`ifdef PFS_ADEL_CHECK_EN
        adel_d     = adel;
`endif
        case (state)
            S_IDLE: begin
                // Nothing in flight: any redirect goes straight into pc.
                if (redirect) begin
                    pc_load  = 1'b1;
                    pc_d     = redirect_target;
                    take_new = 1'b1;
                end else if (pend_valid) begin
                    pc_load   = 1'b1;
                    pc_d      = pend_target;
                    take_pend = 1'b1;
                end
                if (!br_stall)
                    state_next = S_REQ;
            end
            S_REQ: begin
                if (misaligned) begin
                    // No bus request exists, so a flush simply retargets pc.
                    if (flush) begin
                        pc_load  = 1'b1;
                        pc_d     = redirect_target;
                        take_new = 1'b1;
                    end else begin
                        hold_load  = 1'b1;
                        state_next = S_HOLD;
`ifdef PFS_ADEL_CHECK_EN
                        adel_d     = 1'b1;
`endif
                    end
                end else if (inst_sram_addr_ok) begin
                    if (flush || cancel) begin
                        // Accepted request is stale; a same-cycle flush
                        // supersedes any older pending target.
                        cancel_d = 1'b0;
                        pc_load  = 1'b1;
                        if (flush) begin
                            pc_d     = redirect_target;
                            take_new = 1'b1;
                        end else begin
                            pc_d      = pend_target;
                            take_pend = 1'b1;
                        end
                        state_next = br_stall ? S_IDLE : S_REQ;
                    end else begin
                        hold_load  = 1'b1;
                        state_next = S_HOLD;
                    end
                end else if (flush) begin
                    cancel_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (flush) begin
                    pc_load    = 1'b1;
                    pc_d       = redirect_target;
                    take_new   = 1'b1;
                    state_next = S_REQ;
`ifdef PFS_ADEL_CHECK_EN
                    adel_d     = 1'b0;
`endif
                end else if (fs_allowin) begin
                    // A branch arriving on the handoff cycle is bypassed so
                    // the PC after the delay slot is never fetched.
                    pc_load = 1'b1;
                    if (redirect) begin
                        pc_d     = redirect_target;
                        take_new = 1'b1;
                    end else if (pend_valid) begin
                        pc_d      = pend_target;
                        take_pend = 1'b1;
                    end else begin
                        pc_d = pc + 32'd4;
                    end
                    state_next = br_stall ? S_IDLE : S_REQ;
`ifdef PFS_ADEL_CHECK_EN
                    adel_d     = 1'b0;
`endif
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        inst_sram_req  = (state == S_REQ) && !misaligned;
        inst_sram_wr   = 1'b0;
        inst_sram_size = SRAM_SIZE_WORD;
        inst_sram_addr = inst_sram_req ? pc : '0;
        fs_discard     = inst_sram_req && inst_sram_addr_ok && (cancel || flush);
        to_fs_valid    = (state == S_HOLD) && !flush;
        to_fs_pc       = hold_pc;
`ifdef PFS_ADEL_CHECK_EN
        to_fs_excp     = to_fs_valid && adel;
`else
        to_fs_excp     = 1'b0;
`endif
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            pc      <= RESET_PC;
            hold_pc <= RESET_PC;
            cancel  <= 1'b0;
        end else begin
            if (pc_load)
                pc <= pc_d;
            if (hold_load)
                hold_pc <= pc;
            cancel <= cancel_d;
        end
    end

`ifdef PFS_ADEL_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset)
            adel <= 1'b0;
        else
            adel <= adel_d;
    end
`endif

endmodule

// File: tb/tb_pre_if_stage.sv
// tb_pre_if_stage: directed-vector bench for pre_if_stage.
module tb_pre_if_stage;

    logic        clk;
    logic        reset;
    logic        fs_allowin;
    logic        br_stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        excp_flush;
    logic        eret_flush;
    logic [31:0] cp0_epc;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        to_fs_valid;
    logic [31:0] to_fs_pc;
    logic        to_fs_excp;
    logic        fs_discard;

    int unsigned vectors;
    int unsigned miscompares;

    pre_if_stage #(
        .RESET_PC   (32'hbfc00000),
        .EXCP_ENTRY (32'hbfc00380)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .fs_allowin        (fs_allowin),
        .br_stall          (br_stall),
        .br_taken          (br_taken),
        .br_target         (br_target),
        .excp_flush        (excp_flush),
        .eret_flush        (eret_flush),
        .cp0_epc           (cp0_epc),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .to_fs_valid       (to_fs_valid),
        .to_fs_pc          (to_fs_pc),
        .to_fs_excp        (to_fs_excp),
        .fs_discard        (fs_discard)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Check the request/handoff outputs for the current cycle.
    task automatic exp_out(input string tag, input logic req, input logic [31:0] addr,
                           input logic v, input logic [31:0] fpc, input logic disc,
                           input logic excp = 1'b0);
        #1;
        check({tag, ".req"},  {31'd0, inst_sram_req}, {31'd0, req});
        check({tag, ".addr"}, inst_sram_addr, addr);
        check({tag, ".vld"},  {31'd0, to_fs_valid}, {31'd0, v});
        if (v)
            check({tag, ".pc"}, to_fs_pc, fpc);
        check({tag, ".disc"}, {31'd0, fs_discard}, {31'd0, disc});
        check({tag, ".excp"}, {31'd0, to_fs_excp}, {31'd0, excp});
    endtask

    // Leaves the DUT in S_REQ with pc = bfc00000.
    task automatic do_reset();
        reset = 1'b1; fs_allowin = 1'b0; br_stall = 1'b0; br_taken = 1'b0;
        br_target = '0; excp_flush = 1'b0; eret_flush = 1'b0; cp0_epc = '0;
        inst_sram_addr_ok = 1'b0;
        cyc(); cyc();
        exp_out("rst", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("rst.fspc", to_fs_pc, 32'hbfc00000);
        check("rst.size", {30'd0, inst_sram_size}, 32'd2);
        check("rst.wr",   {31'd0, inst_sram_wr}, 32'd0);
        reset = 1'b0;
        exp_out("idle", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        cyc();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;

        // 1: back-to-back fetches
        do_reset();
        inst_sram_addr_ok = 1'b1; fs_allowin = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            exp_out("t1.req", 1'b1, 32'hbfc00000 + 4 * i, 1'b0, 32'h0, 1'b0);
            cyc();
            exp_out("t1.hold", 1'b0, 32'h0, 1'b1, 32'hbfc00000 + 4 * i, 1'b0);
            cyc();
        end

        // 2: addr_ok delayed 3 cycles
        do_reset();
        fs_allowin = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            exp_out("t2.wait", 1'b1, 32'hbfc00000, 1'b0, 32'h0, 1'b0);
            cyc();
        end
        inst_sram_addr_ok = 1'b1;
        exp_out("t2.acc", 1'b1, 32'hbfc00000, 1'b0, 32'h0, 1'b0);
        cyc();
        inst_sram_addr_ok = 1'b0;
        exp_out("t2.hold", 1'b0, 32'h0, 1'b1, 32'hbfc00000, 1'b0);
        cyc();
        exp_out("t2.next", 1'b1, 32'hbfc00004, 1'b0, 32'h0, 1'b0);

        // 3: fs_allowin low for 2 cycles in S_HOLD
        do_reset();
        inst_sram_addr_ok = 1'b1;
        exp_out("t3.req", 1'b1, 32'hbfc00000, 1'b0, 32'h0, 1'b0);
        cyc();
        for (int unsigned i = 0; i < 2; i++) begin
            exp_out("t3.stall", 1'b0, 32'h0, 1'b1, 32'hbfc00000, 1'b0);
            cyc();
        end
        fs_allowin = 1'b1;
        exp_out("t3.go", 1'b0, 32'h0, 1'b1, 32'hbfc00000, 1'b0);
        cyc();
        exp_out("t3.next", 1'b1, 32'hbfc00004, 1'b0, 32'h0, 1'b0);

        // 4: br_taken during S_HOLD of the delay slot
        do_reset();
        inst_sram_addr_ok = 1'b1; fs_allowin = 1'b1;
        cyc(); cyc(); cyc(); cyc();
        exp_out("t4.slotreq", 1'b1, 32'hbfc00008, 1'b0, 32'h0, 1'b0);
        cyc();
        br_taken = 1'b1; br_target = 32'hbfc00100;
        exp_out("t4.slot", 1'b0, 32'h0, 1'b1, 32'hbfc00008, 1'b0);
        cyc();
        br_taken = 1'b0;
        exp_out("t4.tgt", 1'b1, 32'hbfc00100, 1'b0, 32'h0, 1'b0);
        cyc();
        exp_out("t4.tgthold", 1'b0, 32'h0, 1'b1, 32'hbfc00100, 1'b0);

        // 4b: br_taken while the slot request waits for addr_ok (pending path)
        do_reset();
        inst_sram_addr_ok = 1'b0; fs_allowin = 1'b1;
        br_taken = 1'b1; br_target = 32'hbfc00200;
        exp_out("t4b.req", 1'b1, 32'hbfc00000, 1'b0, 32'h0, 1'b0);
        cyc();
        br_taken = 1'b0; inst_sram_addr_ok = 1'b1;
        exp_out("t4b.acc", 1'b1, 32'hbfc00000, 1'b0, 32'h0, 1'b0);
        cyc();
        exp_out("t4b.hold", 1'b0, 32'h0, 1'b1, 32'hbfc00000, 1'b0);
        cyc();
        exp_out("t4b.tgt", 1'b1, 32'hbfc00200, 1'b0, 32'h0, 1'b0);

        // 5: excp_flush in S_REQ, addr_ok 2 cycles later
        do_reset();
        fs_allowin = 1'b1; excp_flush = 1'b1;
        exp_out("t5.flush", 1'b1, 32'hbfc00000, 1'b0, 32'h0, 1'b0);
        cyc();
        excp_flush = 1'b0;
        exp_out("t5.wait", 1'b1, 32'hbfc00000, 1'b0, 32'h0, 1'b0);
        cyc();
        inst_sram_addr_ok = 1'b1;
        exp_out("t5.disc", 1'b1, 32'hbfc00000, 1'b0, 32'h0, 1'b1);
        cyc();
        exp_out("t5.entry", 1'b1, 32'hbfc00380, 1'b0, 32'h0, 1'b0);
        cyc();
        exp_out("t5.hold", 1'b0, 32'h0, 1'b1, 32'hbfc00380, 1'b0);

        // 5b: flush coincident with addr_ok
        do_reset();
        inst_sram_addr_ok = 1'b1; eret_flush = 1'b1; cp0_epc = 32'hbfc00200;
        exp_out("t5b.disc", 1'b1, 32'hbfc00000, 1'b0, 32'h0, 1'b1);
        cyc();
        eret_flush = 1'b0;
        exp_out("t5b.epc", 1'b1, 32'hbfc00200, 1'b0, 32'h0, 1'b0);

        // 6: excp_flush and br_taken together in S_HOLD
        do_reset();
        inst_sram_addr_ok = 1'b1; fs_allowin = 1'b1;
        cyc();
        excp_flush = 1'b1; br_taken = 1'b1; br_target = 32'hbfc00100;
        exp_out("t6.flush", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        cyc();
        excp_flush = 1'b0; br_taken = 1'b0;
        exp_out("t6.entry", 1'b1, 32'hbfc00380, 1'b0, 32'h0, 1'b0);
        cyc();
        eret_flush = 1'b1; cp0_epc = 32'hbfc00102;
        exp_out("t6.eret", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        cyc();
        eret_flush = 1'b0;
`ifdef PFS_ADEL_CHECK_EN
        exp_out("t6.noreq", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        cyc();
        exp_out("t6.adel", 1'b0, 32'h0, 1'b1, 32'hbfc00102, 1'b0, 1'b1);
`else
        exp_out("t6.misreq", 1'b1, 32'hbfc00102, 1'b0, 32'h0, 1'b0);
        cyc();
        exp_out("t6.mishold", 1'b0, 32'h0, 1'b1, 32'hbfc00102, 1'b0);
`endif

        // br_stall on handoff parks in S_IDLE
        do_reset();
        inst_sram_addr_ok = 1'b1; fs_allowin = 1'b1;
        cyc();
        br_stall = 1'b1;
        exp_out("stall.hold", 1'b0, 32'h0, 1'b1, 32'hbfc00000, 1'b0);
        cyc();
        exp_out("stall.idle", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        cyc();
        br_stall = 1'b0;
        exp_out("stall.idle2", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        cyc();
        exp_out("stall.req", 1'b1, 32'hbfc00004, 1'b0, 32'h0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
